mux_scan_ctrl: RTL and testbench

Upstream controller and downstream sampler for the 8-to-1 mux stage. It drives the mux 3-bit select through channels 0..7, holds each select for a programmable dwell time so the mux output can settle, and samples the mux output Y back into an 8-bit word. On completion it presents the word with a done pulse and a valid flag. A start/busy/done handshake connects it to the surrounding lab datapath.

---
 rtl/mux_scan_pkg.sv | 20 ++
 rtl/mux_scan_if.sv | 31 +++
 rtl/scan_dwell_timer.sv | 37 +++
 rtl/mux_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 8-to-1 mux scan controller.
// Holds the FSM state encoding and the select/channel sizing used by every file.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  localparam int SEL_W     = 3;
  localparam int NUM_CH    = 8;
  localparam int DWELL_MAX = 16;

  // A dwell of one cycle still needs a 1-bit counter.
  function automatic int dwell_cnt_width(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_if.sv
// Start/abort/busy/done handshake and result word between the lab datapath
// (master) and the scan controller (slave).
interface mux_scan_if;
  import mux_scan_pkg::*;

  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              valid;
  logic [NUM_CH-1:0] data_out;

  modport master (
    output start,
    output abort,
    input  busy,
    input  done,
    input  valid,
    input  data_out
  );

  modport slave (
    input  start,
    input  abort,
    output busy,
    output done,
    output valid,
    output data_out
  );

endinterface

// File: rtl/scan_dwell_timer.sv
// Dwell counter for one mux select value; tc flags the last cycle of the
// window, which is the cycle on which Y is sampled.
module scan_dwell_timer #(
  parameter int DWELL = 2,
  parameter int CNT_W = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_r;

  assign tc = (cnt_r == TC_VAL);

  // Count up to the terminal value then wrap, so consecutive windows abut.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (tc) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the 8-to-1 mux select through all channels, holds each for DWELL
// cycles, and assembles the sampled Y values into one word.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic             clk,
  input  logic             rst,
  mux_scan_if.slave        bus,
  input  logic             y_in,
  output logic [SEL_W-1:0] sel
);

  localparam int               CNT_W    = dwell_cnt_width(DWELL);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  scan_state_e       state_r, state_s;
  logic [SEL_W-1:0]  sel_r, sel_s;
  logic [NUM_CH-1:0] scratch_r, scratch_s;
  logic [NUM_CH-1:0] data_r, data_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              valid_r, valid_s;
  logic              tc_s;
  logic              cnt_clr_s;
  logic              cnt_en_s;

  // The counter runs only while scanning and restarts from zero on every entry.
  assign cnt_en_s  = (state_r == SCAN);
  assign cnt_clr_s = (state_r != SCAN) || bus.abort;

  scan_dwell_timer #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr_s),
    .en  (cnt_en_s),
    .tc  (tc_s)
  );

  assign sel          = sel_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.valid    = valid_r;
  assign bus.data_out = data_r;

  // State and output registers; reset wins over everything, including mid-scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      sel_r     <= '0;
      scratch_r <= '0;
      data_r    <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      sel_r     <= sel_s;
      scratch_r <= scratch_s;
      data_r    <= data_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      valid_r   <= valid_s;
    end
  end

  // Next-state and next-output logic; everything holds unless a branch says otherwise.
  always_comb begin
    state_s   = state_r;
    sel_s     = sel_r;
    scratch_s = scratch_r;
    data_s    = data_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    valid_s   = valid_r;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s   = SCAN;
          sel_s     = '0;
          scratch_s = '0;
          busy_s    = 1'b1;
          valid_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end

      SCAN: begin
        if (bus.abort) begin
          state_s = IDLE;
          busy_s  = 1'b0;
          sel_s   = '0;
        end else if (tc_s) begin
          scratch_s[sel_r] = y_in;
          if (sel_r == LAST_SEL) begin
            // The final sample bypasses scratch so the word is ready on this edge.
            state_s = DONE;
            data_s  = {y_in, scratch_r[NUM_CH-2:0]};
            busy_s  = 1'b0;
            done_s  = 1'b1;
            valid_s = 1'b1;
          end else begin
            sel_s = sel_r + SEL_W'(1);
          end
        end else begin
          state_s = SCAN;
        end
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
        sel_s   = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one instance at DWELL=2 and one at DWELL=1,
// each fed by a behavioural 8-to-1 mux whose inputs are a bench-held word.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  logic             clk;
  logic             rst;
  logic [7:0]       pat2;
  logic [7:0]       pat1;
  logic [SEL_W-1:0] sel2;
  logic [SEL_W-1:0] sel1;
  logic             y2;
  logic             y1;

  int n_cmp;
  int n_fail;

  mux_scan_if bus2 ();
  mux_scan_if bus1 ();

  assign y2 = pat2[sel2];
  assign y1 = pat1[sel1];

  mux_scan_ctrl #(.DWELL(2)) u_dut2 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus2),
    .y_in (y2),
    .sel  (sel2)
  );

  mux_scan_ctrl #(.DWELL(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus1),
    .y_in (y1),
    .sel  (sel1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first_done;
    int second_done;
    int n_done;
    logic prev_done;
    logic got;

    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    pat2   = 8'h00;
    pat1   = 8'h00;
    bus2.start = 1'b0;
    bus2.abort = 1'b0;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;

    // Reset then idle: {sel,busy,done,valid,data} all zero.
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle2", {2'b00, sel2, bus2.busy, bus2.done, bus2.valid, bus2.data_out}, 16'h0000);
      check("idle1", {2'b00, sel1, bus1.busy, bus1.done, bus1.valid, bus1.data_out}, 16'h0000);
    end

    // Full scan DWELL=2, word 8'h4D.
    pat2 = 8'h4D;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("scan2_busy", {15'd0, bus2.busy}, 16'd1);
      check("scan2_sel", {13'd0, sel2}, 16'(i / 2));
      check("scan2_nodone", {15'd0, bus2.done}, 16'd0);
      tick();
    end
    check("scan2_done", {bus2.busy, bus2.done, bus2.valid}, 16'b011);
    check("scan2_data", {8'd0, bus2.data_out}, 16'h004D);
    tick();
    check("scan2_after", {bus2.busy, bus2.done, bus2.valid}, 16'b001);
    check("scan2_hold", {8'd0, bus2.data_out}, 16'h004D);

    // DWELL=1 with Y tied high, then a second scan to a different word.
    pat1 = 8'hFF;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("scan1_sel", {13'd0, sel1}, 16'(i));
      check("scan1_busy", {15'd0, bus1.busy}, 16'd1);
      tick();
    end
    check("scan1_done", {bus1.busy, bus1.done, bus1.valid}, 16'b011);
    check("scan1_data", {8'd0, bus1.data_out}, 16'h00FF);
    tick();
    pat1 = 8'h12;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    check("rescan1_valid", {bus1.busy, bus1.valid}, 16'b10);
    check("rescan1_hold", {8'd0, bus1.data_out}, 16'h00FF);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("rescan1_midhold", {7'd0, bus1.valid, bus1.data_out}, 16'h00FF);
    end
    tick();
    check("rescan1_done", {bus1.busy, bus1.done, bus1.valid}, 16'b011);
    check("rescan1_data", {8'd0, bus1.data_out}, 16'h0012);

    // Scan to 8'hA5, then abort a second scan at sel=3.
    tick();
    pat2 = 8'hA5;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    repeat (16) tick();
    check("scanA5_done", {15'd0, bus2.done}, 16'd1);
    check("scanA5_data", {8'd0, bus2.data_out}, 16'h00A5);
    tick();
    pat2 = 8'h00;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    repeat (6) tick();
    check("abort_presel", {13'd0, sel2}, 16'd3);
    bus2.abort = 1'b1;
    tick();
    bus2.abort = 1'b0;
    check("abort_flags", {bus2.busy, bus2.done, bus2.valid}, 16'b000);
    check("abort_sel", {13'd0, sel2}, 16'd0);
    check("abort_data", {8'd0, bus2.data_out}, 16'h00A5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_quiet", {bus2.busy, bus2.done}, 16'b00);
    end

    // Reset at sel=5, then a clean scan to 8'h5A.
    pat2 = 8'h5A;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    repeat (10) tick();
    check("rst_presel", {13'd0, sel2}, 16'd5);
    rst = 1'b1;
    tick();
    check("rst_mid", {2'b00, sel2, bus2.busy, bus2.done, bus2.valid, bus2.data_out}, 16'h0000);
    rst = 1'b0;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    check("rst_restart_busy", {15'd0, bus2.busy}, 16'd1);
    repeat (16) tick();
    check("rst_rescan_done", {bus2.busy, bus2.done, bus2.valid}, 16'b011);
    check("rst_rescan_data", {8'd0, bus2.data_out}, 16'h005A);
    tick();

    // Start held for 40 cycles with word 8'h3C: done every 18 cycles.
    pat2 = 8'h3C;
    first_done  = 0;
    second_done = 0;
    n_done      = 0;
    prev_done   = 1'b0;
    bus2.start  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (prev_done) begin
        check("held_no_accept", {15'd0, bus2.busy}, 16'd0);
      end
      if (bus2.done) begin
        n_done++;
        if (n_done == 1) begin
          first_done = c;
        end else if (n_done == 2) begin
          second_done = c;
        end
        check("held_data", {8'd0, bus2.data_out}, 16'h003C);
      end
      prev_done = bus2.done;
    end
    bus2.start = 1'b0;
    check("held_count", 16'(n_done), 16'd2);
    check("held_first", 16'(first_done), 16'd17);
    check("held_gap", 16'(second_done - first_done), 16'd18);

    got = 1'b0;
    for (int w = 0; w < 30 && !got; w++) begin
      tick();
      if (bus2.done) begin
        got = 1'b1;
        check("drain_data", {8'd0, bus2.data_out}, 16'h003C);
      end
    end
    check("drain_done", {15'd0, got}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
